// File: rtl/spectrum_ram_arbiter.sv
// Single-port spectrum RAM arbiter: FFT writer preempts, analysis/synthesis readers share the rest.
// Optional `ARB_ROUND_ROBIN_EN selects round-robin between readers instead of fixed analysis-first.
module spectrum_ram_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 36,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_overrun,
    input  logic              a_req,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_gnt,
    output logic              a_valid,
    input  logic              s_req,
    input  logic              s_lock,
    input  logic [ADDR_W-1:0] s_addr,
    output logic              s_gnt,
    output logic              s_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int PIPE_D = RD_LATENCY + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_A  = 2'd1,
        OWN_S  = 2'd2,
        HOLD_W = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_live;
    logic                r_overrun;
    logic                r_held_s;
    logic [ADDR_W-1:0]   r_last_addr;
    logic [PIPE_D-1:0]   r_vld_pipe;
    logic [PIPE_D-1:0]   r_tag_s_pipe;
    logic [DATA_W-1:0]   r_rd_data;
    logic                w_both_pick_a;
    logic                w_arb_a;
    logic                w_arb_s;
    logic                w_gnt_a;
    logic                w_gnt_s;
    logic                w_any_gnt;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_s <= 1'b1;
        end else if (w_any_gnt) begin
            r_last_s <= w_gnt_s;
        end
    end

    assign w_both_pick_a = r_last_s;
`else
    assign w_both_pick_a = 1'b1;
`endif

    // Reader-vs-reader decision used whenever ownership is free.
    always_comb begin
        w_arb_a = a_req && (!s_req || w_both_pick_a);
        w_arb_s = s_req && !w_arb_a;
    end

    // r_live stays low through the reset-release cycle; writes seen then are dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (!r_live && wr_req) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!r_live) begin
            w_state_nxt = IDLE;
        end else if (wr_req) begin
            if (r_state == OWN_A || r_state == OWN_S) begin
                w_state_nxt = HOLD_W;
            end
        end else if (w_gnt_a) begin
            w_state_nxt = a_lock ? OWN_A : IDLE;
        end else if (w_gnt_s) begin
            w_state_nxt = s_lock ? OWN_S : IDLE;
        end else begin
            w_state_nxt = IDLE;
        end
    end

    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_s = 1'b0;
        if (r_live && !wr_req) begin
            case (r_state)
                IDLE: begin
                    w_gnt_a = w_arb_a;
                    w_gnt_s = w_arb_s;
                end
                OWN_A:  w_gnt_a = a_req;
                OWN_S:  w_gnt_s = s_req;
                HOLD_W: begin
                    if (!r_held_s && a_req && a_lock) begin
                        w_gnt_a = 1'b1;
                    end else if (r_held_s && s_req && s_lock) begin
                        w_gnt_s = 1'b1;
                    end else begin
                        w_gnt_a = w_arb_a;
                        w_gnt_s = w_arb_s;
                    end
                end
                default: begin
                    w_gnt_a = 1'b0;
                    w_gnt_s = 1'b0;
                end
            endcase
        end
    end

    assign w_any_gnt = w_gnt_a || w_gnt_s;

    // Remember which reader the writer interrupted so its burst can resume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_held_s <= 1'b0;
        end else if (r_live && wr_req && (r_state == OWN_A || r_state == OWN_S)) begin
            r_held_s <= (r_state == OWN_S);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_addr <= '0;
        end else if (w_gnt_a) begin
            r_last_addr <= a_addr;
        end else if (w_gnt_s) begin
            r_last_addr <= s_addr;
        end
    end

    always_comb begin
        ram_we  = r_live && wr_req;
        ram_din = ram_we ? wr_data : '0;
        if (ram_we) begin
            ram_addr = wr_addr;
        end else if (w_gnt_a) begin
            ram_addr = a_addr;
        end else if (w_gnt_s) begin
            ram_addr = s_addr;
        end else begin
            ram_addr = r_last_addr;
        end
    end

    // Valid/tag shift pipeline; depth covers RAM latency plus the rd_data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe   <= '0;
            r_tag_s_pipe <= '0;
            r_rd_data    <= '0;
        end else begin
            r_vld_pipe   <= {r_vld_pipe[PIPE_D-2:0], w_any_gnt};
            r_tag_s_pipe <= {r_tag_s_pipe[PIPE_D-2:0], w_gnt_s};
            r_rd_data    <= ram_dout;
        end
    end

    assign a_gnt      = w_gnt_a;
    assign s_gnt      = w_gnt_s;
    assign a_valid    = r_vld_pipe[PIPE_D-1] && !r_tag_s_pipe[PIPE_D-1];
    assign s_valid    = r_vld_pipe[PIPE_D-1] && r_tag_s_pipe[PIPE_D-1];
    assign rd_data    = r_rd_data;
    assign wr_overrun = r_overrun;

endmodule

// File: doc/spectrum_ram_arbiter.md
# spectrum_ram_arbiter

Shares one single-port 36x512 spectrum RAM among three requesters. The FFT unload writer has absolute priority because the FFT core cannot stall. The analysis reader is the CORDIC/peak-finder sweep. The synthesis reader is the IFFT feed. The block sits between the main sequencing FSM and the RAM instance, owns the RAM address/write-enable mux, and returns tagged read data with per-requester valid strobes.

## Interface
- ADDR_W, 9, RAM address width (512 bins)
- DATA_W, 36, RAM word width ({real[17:0], imag[17:0]})
- RD_LATENCY, 1, RAM read latency in cycles (1..3)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_req  in  1  FFT writer strobe; one word per asserted cycle
- wr_addr  in  ADDR_W  write bin index
- wr_data  in  DATA_W  write word
- wr_overrun  out  1  sticky; set if wr_req is asserted during the reset-release cycle; cleared only by reset
- a_req / s_req  in  1  analysis / synthesis read request
- a_lock / s_lock  in  1  hold ownership across a burst while asserted with req
- a_addr / s_addr  in  ADDR_W  read address
- a_gnt / s_gnt  out  1  read accepted this cycle (combinational)
- a_valid / s_valid  out  1  rd_data holds that requester's word
- rd_data  out  DATA_W  shared read return (registered ram_dout)
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_we  out  1  RAM write enable
- ram_dout  in  DATA_W  RAM read data

## Operation
- The owner FSM has four states: IDLE, OWN_A, OWN_S, HOLD_W.
- Each cycle, wr_req wins unconditionally:
  - ram_we=1, ram_addr=wr_addr, ram_din=wr_data.
  - Both gnts are 0.
- If the FSM was in OWN_A or OWN_S, it moves to HOLD_W and remembers the preempted owner.
- With no wr_req:
  - In IDLE, choose a reader: only one requesting gets it; with both requesting, the priority rule (see Configuration) decides.
  - The chosen reader gets gnt=1 and ram_addr=its addr.
  - If that reader's lock is high, go to OWN_A or OWN_S.
- In OWN_x, only x may be granted. Exit to IDLE when x_req=0 or x_lock=0. The grant on the exit cycle is still issued if x_req=1.
- In HOLD_W, the first cycle without wr_req returns to the remembered owner if its req&lock is still high. Otherwise it goes to IDLE and arbitrates normally in the same cycle.
- Read return:
  - A shift pipeline of depth RD_LATENCY+1 carries {valid, tag}.
  - rd_data is ram_dout registered once.
  - x_valid asserts exactly RD_LATENCY+1 cycles after x_gnt.
  - a_valid and s_valid are never both 1.
- ram_addr defaults to the last granted address when idle. This holds the RAM output stable for the peak-readback dwell.

## Timing
- Reset values: FSM=IDLE; a_gnt, s_gnt, a_valid, s_valid, ram_we, wr_overrun = 0; rd_data=0; ram_addr=0; the valid pipeline is cleared.
- Asserting rst_n low mid-burst drops in-flight valids; no late valid appears after release.
- Write latency is 0: the word is presented to the RAM in the same cycle as wr_req.
- Read latency is RD_LATENCY+1 from gnt to valid (2 at default). Throughput is 1 read per cycle.
- A requester must hold req, addr and lock stable until it sees gnt.
- Simultaneous wr_req, a_req and s_req: the write proceeds and both readers stall, with no loss of their requests.
- Address wrap: none. Addresses are passed through unmodified; 511 is a legal address.
- Starvation: readers can starve during a 512-cycle FFT unload. This is accepted because FFT bursts are bounded.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - In IDLE with both readers requesting, the reader that was not granted most recently wins.
  - A 1-bit last-grant register resets to "synthesis", so analysis wins the first contest.
- Undefined:
  - Fixed priority, analysis over synthesis.
  - The last-grant register is absent.

## Test plan
- Reset release, then wr_req for 512 cycles with wr_addr 0..511 and wr_data=addr -> ram_we high for 512 cycles, ram_addr tracks wr_addr, no gnt issued, wr_overrun=0.
- a_req+a_lock for addresses 0..511 after the fill -> a_gnt every cycle, a_valid 2 cycles after each gnt, rd_data=0..511 in order.
- a_lock burst at address 100, then wr_req for 3 cycles at address 300 -> a_gnt low for 3 cycles, write lands; burst resumes at 100 in HOLD_W→OWN_A; s_req meanwhile never granted.
- a_req and s_req both held (no lock) for 4 cycles -> fixed priority: 4 analysis grants; round-robin build: grants alternate a,s,a,s.
- Drive rst_n low one cycle after an s_gnt at address 7 -> s_valid never asserts; all outputs 0 within the reset cycle.
